// File: rtl/param_sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_ram
// Description : Parametrised single-port synchronous RAM with a registered
//               read, a sequential clear engine and out-of-range detection.
//               Optional even-parity storage is enabled by PARAM_RAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module param_sync_ram #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 5,
    parameter int unsigned           DEPTH       = 32,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read_en,
    input  logic                  write_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  addr_err,
    output logic                  parity_err
);

`ifdef PARAM_RAM_PARITY_EN
    localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Stored word layout: parity bit (when enabled) sits above the data bits.
    function automatic logic [WORD_WIDTH-1:0] encode_word(input logic [DATA_WIDTH-1:0] d);
`ifdef PARAM_RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q,    clr_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
    logic                  read_valid_q, read_valid_d;
    logic                  addr_err_q,   addr_err_d;
`ifdef PARAM_RAM_PARITY_EN
    logic                  parity_err_q, parity_err_d;
`endif

    logic                  addr_ok;
    logic [WORD_WIDTH-1:0] rd_word;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WORD_WIDTH-1:0] mem_wdata;

    // Widened compare so DEPTH == 2**ADDR_WIDTH never flags an error.
    assign addr_ok = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));

    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        data_out_d   = data_out_q;
        read_valid_d = 1'b0;
        addr_err_d   = 1'b0;
`ifdef PARAM_RAM_PARITY_EN
        parity_err_d = 1'b0;
`endif
        mem_we       = 1'b0;
        mem_waddr    = address;
        mem_wdata    = encode_word(data_in);
        rd_word      = '0;
        if (addr_ok) begin
            rd_word = mem_q[address];
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = encode_word(CLEAR_VALUE);
                if (clr_ptr_q == LAST_ADDR) begin
                    clr_ptr_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (read_en || write_en) begin
                    if (!addr_ok) begin
                        addr_err_d = 1'b1;
                    end else begin
                        mem_we = write_en;
                        if (read_en) begin
                            // rd_word is the pre-write contents: read-before-write.
                            data_out_d   = rd_word[DATA_WIDTH-1:0];
                            read_valid_d = 1'b1;
`ifdef PARAM_RAM_PARITY_EN
                            parity_err_d = ^rd_word;
`endif
                        end
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
`ifdef PARAM_RAM_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
`ifdef PARAM_RAM_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;
    assign addr_err   = addr_err_q;
    assign busy       = (state_q == ST_CLEAR);
`ifdef PARAM_RAM_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sync_ram
// Description : Self-checking bench for param_sync_ram (DEPTH 32 and 24
//               instances share stimulus); parity case under PARAM_RAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sync_ram;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic [4:0] address = '0;
    logic       read_en = 1'b0;
    logic       write_en = 1'b0;

    logic [7:0] do_a, do_b;
    logic       rv_a, rv_b, bz_a, bz_b, ae_a, ae_b, pe_a, pe_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    param_sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .CLEAR_VALUE(8'h00)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .address(address),
        .read_en(read_en), .write_en(write_en), .data_out(do_a), .read_valid(rv_a),
        .busy(bz_a), .addr_err(ae_a), .parity_err(pe_a)
    );

    param_sync_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(24), .CLEAR_VALUE(8'h00)) dut24 (
        .clock(clock), .reset(reset), .data_in(data_in), .address(address),
        .read_en(read_en), .write_en(write_en), .data_out(do_b), .read_valid(rv_b),
        .busy(bz_b), .addr_err(ae_b), .parity_err(pe_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: per-instance memory, clear countdown and expected outputs.
    int         dep [2] = '{32, 24};
    logic [7:0] m_mem [2][32];
    bit         m_bad [32];
    int         m_cnt [2] = '{0, 0};
    logic       e_busy [2], e_rv [2], e_ae [2], e_pe [2];
    logic [7:0] e_do [2];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            int a;
            a = int'(address);
            if (reset) begin
                m_cnt[k] = 0;
                e_busy[k] = 1'b1;
                e_rv[k] = 1'b0; e_ae[k] = 1'b0; e_pe[k] = 1'b0; e_do[k] = 8'h00;
            end else if (m_cnt[k] < dep[k]) begin
                m_mem[k][m_cnt[k]] = 8'h00;
                if (k == 0) m_bad[m_cnt[k]] = 1'b0;
                m_cnt[k]++;
                e_busy[k] = (m_cnt[k] < dep[k]);
                e_rv[k] = 1'b0; e_ae[k] = 1'b0; e_pe[k] = 1'b0;
            end else begin
                e_busy[k] = 1'b0;
                e_rv[k] = 1'b0; e_ae[k] = 1'b0; e_pe[k] = 1'b0;
                if ((read_en || write_en) && a >= dep[k]) begin
                    e_ae[k] = 1'b1;
                end else begin
                    if (read_en) begin
                        e_rv[k] = 1'b1;
                        e_do[k] = m_mem[k][a];
                        e_pe[k] = (k == 0) && m_bad[a];
                    end
                    if (write_en) begin
                        m_mem[k][a] = data_in;
                        if (k == 0) m_bad[a] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy32", 32'(bz_a), 32'(e_busy[0]));
            chk("rvalid32", 32'(rv_a), 32'(e_rv[0]));
            chk("addrerr32", 32'(ae_a), 32'(e_ae[0]));
            chk("parerr32", 32'(pe_a), 32'(e_pe[0]));
            chk("dout32", 32'(do_a), 32'(e_do[0]));
            chk("busy24", 32'(bz_b), 32'(e_busy[1]));
            chk("rvalid24", 32'(rv_b), 32'(e_rv[1]));
            chk("addrerr24", 32'(ae_b), 32'(e_ae[1]));
            chk("parerr24", 32'(pe_b), 32'(e_pe[1]));
            chk("dout24", 32'(do_b), 32'(e_do[1]));
        end
    end

    task automatic step(input logic re, input logic we, input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        read_en = re; write_en = we; address = a; data_in = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; read_en = 1'b0; write_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 31; i++) idle();
    endtask

    task automatic read_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
        step(1'b1, 1'b0, a, 8'h00);
        idle();
        #1;
        chk({nm, "_data"}, 32'(do_a), 32'(exp));
        chk({nm, "_valid"}, 32'(rv_a), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset, busy for exactly DEPTH cycles, first read sees cleared word
        do_reset();
        chk_en = 1'b1;
        #1 chk("t1_busy_c0", 32'(bz_a), 32'd1);
        for (int i = 1; i < 32; i++) begin
            idle();
            #1 chk("t1_busy_hold", 32'(bz_a), 32'd1);
            if (i == 23) chk("t1_busy24_last", 32'(bz_b), 32'd1);
            if (i == 24) chk("t1_busy24_done", 32'(bz_b), 32'd0);
        end
        step(1'b1, 1'b0, 5'd7, 8'h00);
        #1 chk("t1_busy_c33", 32'(bz_a), 32'd0);
        idle();
        #1 chk("t1_rd7_data", 32'(do_a), 32'h00);
        chk("t1_rd7_valid", 32'(rv_a), 32'd1);
        idle();
        #1 chk("t1_valid_drop", 32'(rv_a), 32'd0);

        // Test 2: writes then read-back
        step(1'b0, 1'b1, 5'd0, 8'hAA);
        step(1'b0, 1'b1, 5'd1, 8'hB3);
        step(1'b0, 1'b1, 5'd10, 8'h1E);
        step(1'b0, 1'b1, 5'd31, 8'h44);
        #1 chk("t2_no_valid_on_wr", 32'(rv_a), 32'd0);
        read_chk("t2_rd0", 5'd0, 8'hAA);
        read_chk("t2_rd1", 5'd1, 8'hB3);
        read_chk("t2_rd10", 5'd10, 8'h1E);
        read_chk("t2_rd31", 5'd31, 8'h44);

        // Test 3: same-address read+write is read-before-write
        step(1'b0, 1'b1, 5'd5, 8'h11);
        step(1'b1, 1'b1, 5'd5, 8'h22);
        idle();
        #1 chk("t3_rbw_old", 32'(do_a), 32'h11);
        read_chk("t3_rd5_new", 5'd5, 8'h22);

        // Test 4: out-of-range on the DEPTH=24 instance
        step(1'b0, 1'b1, 5'd23, 8'h99);
        step(1'b0, 1'b1, 5'd27, 8'h77);
        idle();
        #1 chk("t4_ae_pulse", 32'(ae_b), 32'd1);
        chk("t4_ae32_none", 32'(ae_a), 32'd0);
        idle();
        #1 chk("t4_ae_clear", 32'(ae_b), 32'd0);
        step(1'b1, 1'b0, 5'd27, 8'h00);
        idle();
        #1 chk("t4_rd27_invalid", 32'(rv_b), 32'd0);
        chk("t4_rd27_hold", 32'(do_b), 32'h22);
        chk("t4_rd27_ae", 32'(ae_b), 32'd1);
        chk("t4_rd27_dut32", 32'(do_a), 32'h77);
        step(1'b1, 1'b0, 5'd23, 8'h00);
        idle();
        #1 chk("t4_rd23_data", 32'(do_b), 32'h99);
        chk("t4_rd23_valid", 32'(rv_b), 32'd1);
        chk("t4_rd23_ae", 32'(ae_b), 32'd0);

        // Test 5: reset mid-clear restarts the clear engine
        step(1'b0, 1'b1, 5'd3, 8'h5C);
        do_reset();
        for (int i = 0; i < 9; i++) idle();
        do_reset();
        #1 chk("t5_busy_restart", 32'(bz_a), 32'd1);
        for (int i = 1; i < 32; i++) begin
            if (i == 4) step(1'b0, 1'b1, 5'd3, 8'hEE);
            else if (i == 6) step(1'b1, 1'b0, 5'd3, 8'h00);
            else idle();
            #1 chk("t5_busy_hold", 32'(bz_a), 32'd1);
            if (i == 7) chk("t5_rd_ignored", 32'(rv_a), 32'd0);
        end
        step(1'b1, 1'b0, 5'd3, 8'h00);
        #1 chk("t5_busy_done", 32'(bz_a), 32'd0);
        idle();
        #1 chk("t5_rd3_cleared", 32'(do_a), 32'h00);
        chk("t5_rd3_valid", 32'(rv_a), 32'd1);
        read_chk("t5_rd0_cleared", 5'd0, 8'h00);

`ifdef PARAM_RAM_PARITY_EN
        // Test 6: corrupted parity bit is reported alongside read_valid
        step(1'b0, 1'b1, 5'd2, 8'h0F);
        idle();
        dut.mem_q[2][8] = ~dut.mem_q[2][8];
        m_bad[2] = 1'b1;
        step(1'b1, 1'b0, 5'd2, 8'h00);
        idle();
        #1 chk("t6_perr_set", 32'(pe_a), 32'd1);
        chk("t6_perr_valid", 32'(rv_a), 32'd1);
        chk("t6_perr_data", 32'(do_a), 32'h0F);
        step(1'b1, 1'b0, 5'd0, 8'h00);
        idle();
        #1 chk("t6_perr_clean", 32'(pe_a), 32'd0);
`else
        step(1'b1, 1'b0, 5'd2, 8'h00);
        idle();
        #1 chk("t6_perr_tied", 32'(pe_a), 32'd0);
`endif

        idle();
        idle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
